adder_35_core: RTL and testbench

- Registered 3-bit + 3-bit + carry-in adder slice producing a 4-bit result (3 sum bits plus carry-out).
- Used as one partition of a larger adder, for approximate-logic exploration.
- The arithmetic core is a pure 7-input / 4-output function.
- It is wrapped in a one-deep valid/ready output stage so it can sit in a streaming datapath.

---
 rtl/adder_35_core.sv | 65 ++++++
 tb/tb_adder_35_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/adder_35_core.sv
// Registered WIDTH-bit + WIDTH-bit + carry-in adder slice with a one-deep valid/ready output stage.
// The arithmetic core is a plain ripple-carry chain; the result register only loads on a transfer.
module adder_35_core #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   sum_d, sum_q;
    logic             valid_d, valid_q;
    logic             in_xfer, out_xfer;

    // Exact ripple-carry core; carry[WIDTH] becomes the result MSB.
    always_comb begin
        carry    = '0;
        sum_bits = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_bits[i]  = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    // in_ready depends only on register state and out_ready, never on in_valid.
    assign in_ready = !valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

    always_comb begin
        sum_d   = sum_q;
        valid_d = valid_q;
        if (in_xfer) begin
            // Operands are only sampled on a transfer, so X on idle inputs cannot reach sum.
            sum_d   = {carry[WIDTH], sum_bits};
            valid_d = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_35_core.sv
// Directed bench for adder_35_core: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for the sweep, carry, back-pressure and reset cases.
module tb_adder_35_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] a = '0;
    logic [2:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] sum;

    int n_cmp = 0;
    int n_fail = 0;

    adder_35_core #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a one-entry result slot holding the integer sum of the last accepted bundle.
    logic m_valid;
    int   m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sum   <= 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_sum   <= int'(a) + int'(b) + int'(cin);
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model out_valid", int'(out_valid), int'(m_valid));
            check("model in_ready", int'(in_ready), int'(!m_valid || out_ready));
            check("model sum", int'(sum), m_sum);
        end
    end

    // Drive one cycle: set inputs, then step past the next rising edge.
    task automatic drive(input logic v, input logic [2:0] ta, input logic [2:0] tb,
                         input logic tc, input logic rdy);
        in_valid  = v;
        a         = ta;
        b         = tb;
        cin       = tc;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] pi;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset sum", int'(sum), 0);
        check("reset in_ready", int'(in_ready), 1);

        // Exhaustive sweep, one bundle per cycle.
        for (int v = 0; v < 128; v++) begin
            pi = 7'(v);
            drive(1'b1, pi[6:4], pi[3:1], pi[0], 1'b1);
            if (v == 0)   check("sweep 0000000", int'(sum), 0);
            if (v == 1)   check("sweep 0000001", int'(sum), 1);
            if (v == 112) check("sweep 1110000", int'(sum), 7);
            if (v == 126) check("sweep 1111110", int'(sum), 14);
            if (v == 127) check("sweep 1111111", int'(sum), 15);
        end

        drive(1'b1, 3'd4, 3'd3, 1'b0, 1'b1);
        check("carry 4+3+0", int'(sum), 7);
        drive(1'b1, 3'd4, 3'd3, 1'b1, 1'b1);
        check("carry 4+3+1", int'(sum), 8);

        // Back-pressure.
        drive(1'b1, 3'd5, 3'd6, 1'b1, 1'b1);
        check("bp load", int'(sum), 12);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'(i + 1), 3'(7 - i), 1'b0, 1'b0);
            check("bp hold sum", int'(sum), 12);
            check("bp hold valid", int'(out_valid), 1);
            check("bp in_ready", int'(in_ready), 0);
        end
        drive(1'b1, 3'd1, 3'd1, 1'b0, 1'b1);
        check("bp drain next", int'(sum), 2);
        check("bp drain valid", int'(out_valid), 1);

        // Simultaneous input and output transfer.
        drive(1'b1, 3'd3, 3'd3, 1'b0, 1'b1);
        check("simul first", int'(sum), 6);
        drive(1'b1, 3'd2, 3'd2, 1'b0, 1'b1);
        check("simul sum", int'(sum), 4);
        check("simul valid", int'(out_valid), 1);

        // Async reset between edges with a valid result held.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", int'(out_valid), 0);
        check("async rst sum", int'(sum), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("post rst in_ready", int'(in_ready), 1);
        drive(1'b1, 3'd6, 3'd1, 1'b1, 1'b1);
        check("post rst sum", int'(sum), 8);
        check("post rst valid", int'(out_valid), 1);

        // Drain then idle with garbage operands.
        drive(1'b0, 3'd7, 3'd7, 1'b1, 1'b1);
        check("drain valid", int'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'(i * 3), 3'(i + 2), 1'(i), 1'b1);
            check("idle valid", int'(out_valid), 0);
            check("idle sum", int'(sum), 8);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
